// File: rtl/rotator_pkg.sv
// Shared encodings for the rotary quadrature generator:
// FSM states, detent direction and the per-phase (a,b) patterns.
package rotator_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        P1   = 3'd1,
        P2   = 3'd2,
        P3   = 3'd3,
        P4   = 3'd4
    } rot_state_t;

    typedef enum logic {
        DIR_R = 1'b0,
        DIR_L = 1'b1
    } rot_dir_t;

    // (a,b) for P1..P4, P1 in the top two bits
    localparam logic [7:0] PAT_R = {2'b01, 2'b11, 2'b10, 2'b00};
    localparam logic [7:0] PAT_L = {2'b10, 2'b11, 2'b01, 2'b00};

    function automatic logic [1:0] phase_ab(
        input rot_dir_t   dir,
        input rot_state_t st
    );
        logic [7:0] pat;
        logic [1:0] ab;
        pat = (dir == DIR_R) ? PAT_R : PAT_L;
        ab  = 2'b00;
        case (st)
            P1:      ab = pat[7:6];
            P2:      ab = pat[5:4];
            P3:      ab = pat[3:2];
            P4:      ab = pat[1:0];
            default: ab = 2'b00;
        endcase
        return ab;
    endfunction

endpackage

// File: rtl/rotator_step_accum.sv
// Signed saturating net-step counter with a sticky overflow flag.
// The range is symmetric; the most-negative code is never produced.
module rotator_step_accum
    import rotator_pkg::*;
#(
    parameter int PEND_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     step_r,
    input  logic                     step_l,
    input  logic                     consume,
    input  logic                     clr_ovf,
    output logic signed [PEND_W-1:0] pending,
    output logic                     overflow
);

    localparam int XW = PEND_W + 2;
    localparam logic signed [XW-1:0] ONE  = XW'(1);
    localparam logic signed [XW-1:0] MONE = '1;
    localparam logic signed [XW-1:0] ZERO = '0;
    localparam logic signed [XW-1:0] LIM  = XW'(2 ** (PEND_W - 1) - 1);

    logic signed [XW-1:0] ext;
    logic signed [XW-1:0] req;
    logic signed [XW-1:0] dec;
    logic signed [XW-1:0] sum;
    logic                 drop;
    logic [PEND_W-1:0]    pending_n;

    always_comb begin
        ext = {{2{pending[PEND_W-1]}}, pending};
        req = ZERO;
        if (step_r && !step_l) begin
            req = ONE;
        end else if (step_l && !step_r) begin
            req = MONE;
        end
        dec = ZERO;
        if (consume && (pending != '0)) begin
            dec = pending[PEND_W-1] ? MONE : ONE;
        end
        sum  = ext + req - dec;
        drop = (sum > LIM) || (sum < -LIM);
        // a dropped request still lets the detent consume its step
        pending_n = drop ? (pending - dec[PEND_W-1:0])
                         : sum[PEND_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            pending <= pending_n;
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/rotator_quadrature_gen.sv
// Rotary-encoder emulator: plays queued detents as registered
// 4-phase quadrature cycles on rot_a/rot_b.
module rotator_quadrature_gen
    import rotator_pkg::*;
#(
    parameter int PHASE_CYCLES = 4,
    parameter int PEND_W       = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     step_r,
    input  logic                     step_l,
    input  logic                     clr_ovf,
    output logic                     rot_a,
    output logic                     rot_b,
    output logic                     busy,
    output logic                     detent_done,
    output logic signed [PEND_W-1:0] pending,
    output logic                     overflow
);

    localparam int TW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(PHASE_CYCLES - 1);

    rot_state_t               state;
    rot_state_t               state_n;
    rot_dir_t                 dir;
    rot_dir_t                 dir_n;
    logic [TW-1:0]            timer;
    logic [TW-1:0]            timer_n;
    logic [1:0]               ab_n;
    logic                     phase_end;
    logic                     start;
    logic signed [PEND_W-1:0] pend_q;

    rotator_step_accum #(
        .PEND_W (PEND_W)
    ) u_accum (
        .clk      (clk),
        .rst      (rst),
        .step_r   (step_r),
        .step_l   (step_l),
        .consume  (start),
        .clr_ovf  (clr_ovf),
        .pending  (pend_q),
        .overflow (overflow)
    );

    assign pending     = pend_q;
    assign phase_end   = (timer == T_LAST);
    assign busy        = (state != IDLE);
    assign detent_done = (state == P4) && phase_end;

    // A detent may begin from IDLE or chain directly off the last P4 clock
    assign start = ((state == IDLE) || ((state == P4) && phase_end))
                   && (pend_q != '0);

    always_comb begin
        state_n = state;
        dir_n   = dir;
        timer_n = '0;
        if (start) begin
            state_n = P1;
            dir_n   = pend_q[PEND_W-1] ? DIR_L : DIR_R;
        end else if (state != IDLE) begin
            if (!phase_end) begin
                timer_n = timer + TW'(1);
            end else begin
                case (state)
                    P1:      state_n = P2;
                    P2:      state_n = P3;
                    P3:      state_n = P4;
                    default: state_n = IDLE;
                endcase
            end
        end
        ab_n = phase_ab(dir_n, state_n);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            dir   <= DIR_R;
            timer <= '0;
            rot_a <= 1'b0;
            rot_b <= 1'b0;
        end else begin
            state <= state_n;
            dir   <= dir_n;
            timer <= timer_n;
            rot_a <= ab_n[1];
            rot_b <= ab_n[0];
        end
    end

endmodule

// File: tb/tb_rotator_quadrature_gen.sv
// Randomized and directed bench for rotator_quadrature_gen against
// a detent-level reference model and a quadrature decoder model.
module tb_rotator_quadrature_gen;

    localparam int PC   = 4;
    localparam int PW   = 4;
    localparam int MAXV = 7;
    localparam int DLEN = 4 * PC;

    logic                 clk;
    logic                 rst;
    logic                 step_r;
    logic                 step_l;
    logic                 clr_ovf;
    logic                 rot_a;
    logic                 rot_b;
    logic                 busy;
    logic                 detent_done;
    logic signed [PW-1:0] pending;
    logic                 overflow;

    rotator_quadrature_gen #(
        .PHASE_CYCLES (PC),
        .PEND_W       (PW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .step_r      (step_r),
        .step_l      (step_l),
        .clr_ovf     (clr_ovf),
        .rot_a       (rot_a),
        .rot_b       (rot_b),
        .busy        (busy),
        .detent_done (detent_done),
        .pending     (pending),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: net queue, detent position, direction
    int m_pend = 0;
    bit m_ovf  = 0;
    bit m_act  = 0;
    int m_k    = 0;
    int m_dir  = 1;

    function automatic logic [1:0] ref_ab(input int d, input int ph);
        logic [1:0] seq [4];
        if (d > 0) seq = '{2'b01, 2'b11, 2'b10, 2'b00};
        else       seq = '{2'b10, 2'b11, 2'b01, 2'b00};
        return seq[ph];
    endfunction

    function automatic logic [8:0] exp_vec();
        logic [1:0] ab;
        logic       dn;
        ab = m_act ? ref_ab(m_dir, m_k / PC) : 2'b00;
        dn = m_act && (m_k == DLEN - 1);
        return {ab, m_act, dn, 4'(m_pend), m_ovf};
    endfunction

    function automatic logic [8:0] obs();
        return {rot_a, rot_b, busy, detent_done, pending, overflow};
    endfunction

    task automatic tick(input bit r, input bit l, input bit c, input bit rs);
        int req;
        int cns;
        int nxt;
        bit st;
        step_r  = r;
        step_l  = l;
        clr_ovf = c;
        rst     = rs;
        @(posedge clk);
        if (rs) begin
            m_pend = 0; m_ovf = 0; m_act = 0; m_k = 0; m_dir = 1;
        end else begin
            st  = (!m_act || m_k == DLEN - 1) && (m_pend != 0);
            req = (r && !l) ? 1 : ((l && !r) ? -1 : 0);
            cns = st ? ((m_pend > 0) ? 1 : -1) : 0;
            nxt = m_pend + req - cns;
            if (c) m_ovf = 0;
            if (nxt > MAXV || nxt < -MAXV) begin
                nxt   = m_pend - cns;
                m_ovf = 1;
            end
            if (st) begin
                m_dir = (m_pend > 0) ? 1 : -1;
                m_act = 1;
                m_k   = 0;
            end else if (m_act) begin
                if (m_k == DLEN - 1) m_act = 0;
                else m_k++;
            end
            m_pend = nxt;
        end
        #1;
    endtask

    // downstream quadrature decoder: one oneshot per full 4-edge cycle
    logic [1:0] dec_prev = 2'b00;
    int         dec_acc  = 0;
    int         dec_r    = 0;
    int         dec_l    = 0;

    function automatic int qpos(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            dec_acc  <= 0;
            dec_prev <= 2'b00;
        end else if ({rot_a, rot_b} != dec_prev) begin
            int d;
            int a;
            d = (qpos({rot_a, rot_b}) - qpos(dec_prev) + 4) % 4;
            a = dec_acc + ((d == 1) ? 1 : ((d == 3) ? -1 : 0));
            if ({rot_a, rot_b} == 2'b00) begin
                if (a >= 4)  dec_r <= dec_r + 1;
                if (a <= -4) dec_l <= dec_l + 1;
                a = 0;
            end
            dec_acc  <= a;
            dec_prev <= {rot_a, rot_b};
        end
    end

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 0, 1);
            n_cmp++;
            if (obs() !== 9'b0) begin
                n_bad++;
                $display("FAIL reset cyc%0d: got %b want %b", i, obs(), 9'b0);
            end
        end
        tick(0, 0, 0, 0);
        n_cmp++;
        if (obs() !== exp_vec()) begin
            n_bad++;
            $display("FAIL reset_idle: got %b want %b", obs(), exp_vec());
        end
    endtask

    task automatic test_single(input bit right);
        logic [1:0] seq [$];
        logic [1:0] last;
        logic [1:0] want [4];
        int first_edge;
        int done_at;
        int dones;
        int r0;
        int l0;
        r0 = dec_r;
        l0 = dec_l;
        first_edge = -1;
        done_at = -1;
        dones = 0;
        last = 2'b00;
        for (int i = 0; i < 22; i++) begin
            tick(right && i == 0, !right && i == 0, 0, 0);
            n_cmp++;
            if (obs() !== exp_vec()) begin
                n_bad++;
                $display("FAIL single%0d cyc%0d: got %b want %b",
                         right, i, obs(), exp_vec());
            end
            if ({rot_a, rot_b} != 2'b00 && first_edge < 0) first_edge = i;
            if ({rot_a, rot_b} != last) seq.push_back({rot_a, rot_b});
            last = {rot_a, rot_b};
            if (detent_done) begin
                dones++;
                done_at = i;
            end
        end
        @(negedge clk);
        if (right) want = '{2'b01, 2'b11, 2'b10, 2'b00};
        else       want = '{2'b10, 2'b11, 2'b01, 2'b00};
        n_cmp++;
        if (seq.size() != 4 || seq[0] !== want[0] || seq[1] !== want[1]
            || seq[2] !== want[2] || seq[3] !== want[3]) begin
            n_bad++;
            $display("FAIL single%0d_seq: got %0d edges, want 4 in order",
                     right, seq.size());
        end
        n_cmp++;
        if (first_edge != 1 || done_at != DLEN || dones != 1) begin
            n_bad++;
            $display("FAIL single%0d_timing: got edge %0d done %0d x%0d want 1 %0d x1",
                     right, first_edge, done_at, dones, DLEN);
        end
        n_cmp++;
        if ((dec_r - r0) != (right ? 1 : 0) || (dec_l - l0) != (right ? 0 : 1)) begin
            n_bad++;
            $display("FAIL single%0d_decoder: got r%0d l%0d", right,
                     dec_r - r0, dec_l - l0);
        end
    endtask

    task automatic test_back_to_back();
        int maxp;
        int nbusy;
        int first_b;
        int last_b;
        int dones;
        maxp = 0; nbusy = 0; first_b = -1; last_b = -1; dones = 0;
        for (int i = 0; i < 60; i++) begin
            tick(i < 3, 0, 0, 0);
            n_cmp++;
            if (obs() !== exp_vec()) begin
                n_bad++;
                $display("FAIL b2b cyc%0d: got %b want %b", i, obs(), exp_vec());
            end
            if (int'(pending) > maxp) maxp = int'(pending);
            if (busy) begin
                nbusy++;
                if (first_b < 0) first_b = i;
                last_b = i;
            end
            if (detent_done) dones++;
        end
        n_cmp++;
        if (maxp != 2 || nbusy != 48 || last_b - first_b != 47 || dones != 3) begin
            n_bad++;
            $display("FAIL b2b_summary: got maxp %0d busy %0d span %0d done %0d want 2 48 47 3",
                     maxp, nbusy, last_b - first_b, dones);
        end
    endtask

    task automatic test_cancel();
        bit active;
        active = 0;
        for (int i = 0; i < 10; i++) begin
            tick(i == 0, i == 0, 0, 0);
            n_cmp++;
            if (obs() !== exp_vec()) begin
                n_bad++;
                $display("FAIL cancel cyc%0d: got %b want %b", i, obs(), exp_vec());
            end
            if (busy || rot_a || rot_b || pending != 0 || overflow) active = 1;
        end
        n_cmp++;
        if (active) begin
            n_bad++;
            $display("FAIL cancel_quiet: got activity 1 want 0");
        end
    endtask

    task automatic test_saturate();
        int dones;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1, 0, 0, 0);
            if (detent_done) dones++;
        end
        n_cmp++;
        if (pending !== 4'sd7 || overflow !== 1'b1) begin
            n_bad++;
            $display("FAIL sat_limit: got pend %0d ovf %b want 7 1", pending, overflow);
        end
        tick(1, 0, 1, 0);
        if (detent_done) dones++;
        n_cmp++;
        if (overflow !== 1'b1 || obs() !== exp_vec()) begin
            n_bad++;
            $display("FAIL sat_set_wins: got %b want %b", obs(), exp_vec());
        end
        tick(0, 0, 1, 0);
        if (detent_done) dones++;
        n_cmp++;
        if (overflow !== 1'b0 || pending !== 4'sd7) begin
            n_bad++;
            $display("FAIL sat_clear: got ovf %b pend %0d want 0 7", overflow, pending);
        end
        for (int i = 0; i < 130; i++) begin
            tick(0, 0, 0, 0);
            n_cmp++;
            if (obs() !== exp_vec()) begin
                n_bad++;
                $display("FAIL sat_drain cyc%0d: got %b want %b", i, obs(), exp_vec());
            end
            if (detent_done) dones++;
        end
        n_cmp++;
        if (dones != 8 || busy !== 1'b0 || pending !== 4'sd0) begin
            n_bad++;
            $display("FAIL sat_drain_done: got %0d detents busy %b want 8 0", dones, busy);
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        for (int i = 0; i < 4; i++) tick(1, 0, 0, 0);
        guard = 0;
        while ({rot_a, rot_b} != 2'b11 && guard < 20) begin
            tick(0, 0, 0, 0);
            guard++;
        end
        n_cmp++;
        if (guard >= 20 || pending !== 4'sd3) begin
            n_bad++;
            $display("FAIL rstmid_p2: got pend %0d wait %0d want 3 <20", pending, guard);
        end
        tick(0, 0, 0, 1);
        n_cmp++;
        if (obs() !== 9'b0) begin
            n_bad++;
            $display("FAIL rstmid_clear: got %b want %b", obs(), 9'b0);
        end
        for (int i = 0; i < 6; i++) begin
            tick(0, 0, 0, 0);
            n_cmp++;
            if (obs() !== exp_vec()) begin
                n_bad++;
                $display("FAIL rstmid_after cyc%0d: got %b want %b", i, obs(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        bit r;
        bit l;
        bit c;
        bit rs;
        for (int i = 0; i < 1500; i++) begin
            r  = ($urandom_range(0, 5) == 0);
            l  = ($urandom_range(0, 5) == 0);
            c  = ($urandom_range(0, 15) == 0);
            rs = ($urandom_range(0, 299) == 0);
            tick(r, l, c, rs);
            n_cmp++;
            if (obs() !== exp_vec()) begin
                n_bad++;
                $display("FAIL random cyc%0d: got %b want %b", i, obs(), exp_vec());
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        step_r = 1'b0;
        step_l = 1'b0;
        clr_ovf = 1'b0;
        test_reset();
        test_single(1);
        test_single(0);
        test_back_to_back();
        test_cancel();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
